ref_mem_ctrl_param: RTL and testbench
=====================================

Name: ref_mem_ctrl_param

Overview:
- Parametrised reference-frame memory controller for the DMT integer motion-estimation array.
- Three jobs:
  - Preloads the banked reference SRAM group by group, under a loader handshake.
  - Primes the PE array with the first rows.
  - Sweeps the sub-area-1 search columns, generating per-bank read addresses, the PE shift amount and row-reuse repeats.
- Adds three things the fixed 32-bank controller lacks: PE back-pressure, a start/done handshake, and a generic bank/band geometry.

Parameters:
- NUM_BANK, 32, number of reference SRAM banks.
- ADDR_W, 7, address bits per bank.
- GRP_BANKS, 4, banks written together during preload.
- PRE_ROWS, 96, rows written per bank group.
- BLK_ROWS, 24, rows per band (one sub-block pair).
- NUM_COL, 7, search columns in sub-area 1.
- SHIFT_STEP, 8, banks moved per column step.
- PRIME_ROWS, 4, rows read before the sweep starts.
- REP_LO, 7, first row of the reuse window.
- REP_HI, 19, last row of the reuse window.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- begin_prepare  in  1  start pulse; sampled in IDLE only.
- wr_valid  in  1  loader has a row ready this cycle.
- pe_ready  in  1  PE array accepts the current read.
- Bank_sel  out  NUM_BANK  write-enable mask, one bit per bank.
- wr_en  out  1  write strobe.
- write_address_all  out  NUM_BANK*ADDR_W  per-bank write address; bank b occupies slice b (bank 0 = LSBs).
- rd_en  out  1  read strobe.
- rd_address_all  out  NUM_BANK*ADDR_W  per-bank read address; same slicing.
- shift_value  out  $clog2(NUM_BANK)  PE shift in banks.
- col_idx  out  $clog2(NUM_COL+1)  current sweep column.
- half  out  1  0 = sub-blocks 1/2, 1 = sub-blocks 3/4.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at end of sweep.

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; all counters 0. Reset mid-operation aborts immediately, with no done pulse.
- All outputs are registered. They reflect the state and counters of the previous cycle, i.e. one-cycle latency.
- Derived constant: NGRP = NUM_BANK/GRP_BANKS.

States:
- IDLE -> PRELOAD on begin_prepare.
- PRELOAD:
  - Group g = 0..NGRP-1, row r = 0..PRE_ROWS-1.
  - On a wr_valid cycle: wr_en=1, Bank_sel = ((1<<GRP_BANKS)-1) << (g*GRP_BANKS), every address slice = r, then advance r. r wraps to 0 and g increments.
  - On a cycle without wr_valid: wr_en=0 and Bank_sel=0, with no advance.
  - After the last write (g=NGRP-1, r=PRE_ROWS-1) -> PRIME.
- PRIME:
  - rd_en=1, all read slices = p, for p = 0..PRIME_ROWS-1.
  - p advances only when pe_ready; after the last p -> SWEEP.
- SWEEP:
  - Loops: column c = 0..NUM_COL-1, half h = 0..1, row r = 0..BLK_ROWS-1.
  - Per cycle: K = NUM_BANK/SHIFT_STEP, split = (c mod K)*SHIFT_STEP, band = c div K + h.
  - Bank b < split gets address r + (band+1)*BLK_ROWS.
  - Every other bank gets address r + band*BLK_ROWS.
  - shift_value = split.
  - Addresses are truncated to ADDR_W bits. Elaboration fails if (NUM_COL-1)/K+2 times BLK_ROWS exceeds 2**ADDR_W.
  - Reuse: when r is in [REP_LO, REP_HI], row r is issued twice on consecutive accepted cycles (rep flag 0 then 1). r advances only after the rep=1 issue; rep clears on advance.
  - Accepted cycles per half = BLK_ROWS + (REP_HI - REP_LO + 1), i.e. 37 at defaults.
  - After the last row of h=1 in column c: c increments. After c=NUM_COL-1 -> DONE.
- DONE: done=1 and rd_en=0 for one cycle, then -> IDLE with busy=0.
- Back-pressure:
  - pe_ready low in PRIME or SWEEP holds all counters.
  - rd_en and addresses stay stable until the cycle after pe_ready returns high.
  - pe_ready is ignored in PRELOAD.
- Ignored inputs: begin_prepare while busy; wr_valid outside PRELOAD.
- col_idx and half mirror c and h during SWEEP; both are 0 otherwise.

Decomposition:
- Package ref_mem_pkg holds:
  - state enum {IDLE, PRELOAD, PRIME, SWEEP, DONE};
  - a function computing split and band from (c, h);
  - the localparams NGRP and K.
- One sub-module, ref_addr_gen: combinational mapping of (r, band, split) to the NUM_BANK-slice address vector.
- The FSM and counters stay in the top level.

Test Plan:
- Reset mid-SWEEP with rst_n low at c=3 -> all outputs 0 the same edge; busy=0; no done.
- begin_prepare, wr_valid held high -> 768 wr_en cycles. Bank_sel=0x0000000F with addresses 0..95, then 0x000000F0 ... 0xF0000000. Then PRIME reads 0,1,2,3.
- wr_valid toggled 1/0 -> PRELOAD takes 1536 cycles; wr_en=0 and Bank_sel=0 on the low cycles; address sequence unchanged.
- Sweep at c=1, h=0, r=0 -> banks 0-7 address 24, banks 8-31 address 0, shift_value=8. At c=4, h=1, r=5 -> all banks address 53, shift_value=0.
- Repeat check, c=0, h=0 -> address sequence 0..6, 7,7, 8,8, ... 19,19, 20..23; 37 accepted cycles in total.
- pe_ready low for 5 cycles at r=10 -> rd_address_all frozen. With pe_ready always high, done pulses exactly 7*2*37 = 518 cycles after the first SWEEP read and is followed by IDLE.

Source files
------------

// File: rtl/ref_mem_pkg.sv
// Shared types and helpers for the reference-frame memory controller.
package ref_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRELOAD,
    PRIME,
    SWEEP,
    DONE
  } state_e;

  // Geometry at the default configuration (32 banks, groups of 4, step of 8).
  localparam int unsigned NUM_BANK_DEF   = 32;
  localparam int unsigned GRP_BANKS_DEF  = 4;
  localparam int unsigned SHIFT_STEP_DEF = 8;
  localparam int unsigned NGRP           = NUM_BANK_DEF / GRP_BANKS_DEF;
  localparam int unsigned K              = NUM_BANK_DEF / SHIFT_STEP_DEF;

  typedef struct packed {
    int unsigned split;
    int unsigned band;
  } geom_t;

  // Column c walks the shift window across K positions before moving down one band.
  function automatic geom_t sweep_geom(input int unsigned c, input int unsigned h,
                                       input int unsigned k, input int unsigned step);
    geom_t g;
    g.split = (c % k) * step;
    g.band  = c / k + h;
    return g;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ref_mem_ctrl_param_if.sv
// Loader / PE-array side bus of the reference memory controller.
interface ref_mem_ctrl_param_if
  import ref_mem_pkg::*;
#(
  parameter int unsigned NUM_BANK = 32,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned NUM_COL  = 7
);
  localparam int unsigned SW = min1_clog2(NUM_BANK);
  localparam int unsigned CW = min1_clog2(NUM_COL + 1);

  logic                       begin_prepare;
  logic                       wr_valid;
  logic                       pe_ready;
  logic [NUM_BANK-1:0]        Bank_sel;
  logic                       wr_en;
  logic [NUM_BANK*ADDR_W-1:0] write_address_all;
  logic                       rd_en;
  logic [NUM_BANK*ADDR_W-1:0] rd_address_all;
  logic [SW-1:0]              shift_value;
  logic [CW-1:0]              col_idx;
  logic                       half;
  logic                       busy;
  logic                       done;

  // Controller side.
  modport master (
    input  begin_prepare, wr_valid, pe_ready,
    output Bank_sel, wr_en, write_address_all, rd_en, rd_address_all,
    output shift_value, col_idx, half, busy, done
  );

  // Loader / PE-array side.
  modport slave (
    output begin_prepare, wr_valid, pe_ready,
    input  Bank_sel, wr_en, write_address_all, rd_en, rd_address_all,
    input  shift_value, col_idx, half, busy, done
  );

endinterface

// File: rtl/ref_addr_gen.sv
// Per-bank sweep read addresses: banks below split already hold the next band.
module ref_addr_gen #(
  parameter int unsigned NUM_BANK = 32,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned BLK_ROWS = 24
) (
  input  logic [ADDR_W-1:0]          row,
  input  int unsigned                band,
  input  int unsigned                split,
  output logic [NUM_BANK*ADDR_W-1:0] addr_all
);

  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W-1:0] addr_hi;

  // Two candidate addresses, then a per-bank pick against the split point.
  always_comb begin
    addr_all = '0;
    addr_lo  = ADDR_W'(32'(row) + band * BLK_ROWS);
    addr_hi  = ADDR_W'(32'(row) + (band + 1) * BLK_ROWS);
    for (int b = 0; b < int'(NUM_BANK); b++) begin
      addr_all[b*ADDR_W +: ADDR_W] = (unsigned'(b) < split) ? addr_hi : addr_lo;
    end
  end

endmodule

// File: rtl/ref_mem_ctrl_param.sv
// Reference-frame memory controller: banked preload, PE priming and sub-area-1 sweep.
module ref_mem_ctrl_param
  import ref_mem_pkg::*;
#(
  parameter int unsigned NUM_BANK   = 32,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned GRP_BANKS  = 4,
  parameter int unsigned PRE_ROWS   = 96,
  parameter int unsigned BLK_ROWS   = 24,
  parameter int unsigned NUM_COL    = 7,
  parameter int unsigned SHIFT_STEP = 8,
  parameter int unsigned PRIME_ROWS = 4,
  parameter int unsigned REP_LO     = 7,
  parameter int unsigned REP_HI     = 19
) (
  input logic clk,
  input logic rst_n,
  ref_mem_ctrl_param_if.master bus
);

  localparam int unsigned GRPS = NUM_BANK / GRP_BANKS;
  localparam int unsigned KCOL = NUM_BANK / SHIFT_STEP;
  localparam int unsigned SW   = min1_clog2(NUM_BANK);
  localparam int unsigned CW   = min1_clog2(NUM_COL + 1);
  localparam int unsigned GW   = min1_clog2(GRPS);
  localparam int unsigned AW   = NUM_BANK * ADDR_W;
  localparam logic [NUM_BANK-1:0] GRP_MASK0 = NUM_BANK'({GRP_BANKS{1'b1}});

  if (NUM_BANK % GRP_BANKS != 0 || NUM_BANK % SHIFT_STEP != 0) begin : g_chk_div
    $error("bank count must divide evenly into groups and shift steps");
  end
  if (((NUM_COL - 1) / KCOL + 2) * BLK_ROWS > (1 << ADDR_W)) begin : g_chk_addr
    $error("sweep bands exceed the per-bank address space");
  end
  if (PRE_ROWS > (1 << ADDR_W) || PRIME_ROWS == 0 || PRIME_ROWS > (1 << ADDR_W)) begin : g_chk_rows
    $error("preload or prime row count does not fit the address space");
  end
  if (REP_LO > REP_HI || REP_HI >= BLK_ROWS) begin : g_chk_rep
    $error("reuse window must lie inside one band");
  end

  state_e            state_q, state_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic [ADDR_W-1:0] row_q, row_d;   // shared by preload, prime and sweep
  logic              rep_q, rep_d;
  logic              half_q, half_d;
  logic [CW-1:0]     col_q, col_d;

  logic [NUM_BANK-1:0] bank_sel_q, bank_sel_d;
  logic                wr_en_q, wr_en_d;
  logic [AW-1:0]       waddr_q, waddr_d;
  logic                rd_en_q, rd_en_d;
  logic [AW-1:0]       raddr_q, raddr_d;
  logic [SW-1:0]       shift_q, shift_d;
  logic [CW-1:0]       col_idx_q, col_idx_d;
  logic                half_o_q, half_o_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  geom_t         geom;
  logic [AW-1:0] sweep_addr;
  logic          in_win;

  assign geom   = sweep_geom(32'(col_q), 32'(half_q), KCOL, SHIFT_STEP);
  assign in_win = (row_q >= ADDR_W'(REP_LO)) && (row_q <= ADDR_W'(REP_HI));

  ref_addr_gen #(
    .NUM_BANK (NUM_BANK),
    .ADDR_W   (ADDR_W),
    .BLK_ROWS (BLK_ROWS)
  ) u_addr_gen (
    .row      (row_q),
    .band     (geom.band),
    .split    (geom.split),
    .addr_all (sweep_addr)
  );

  // State and counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grp_q   <= '0;
      row_q   <= '0;
      rep_q   <= 1'b0;
      half_q  <= 1'b0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      row_q   <= row_d;
      rep_q   <= rep_d;
      half_q  <= half_d;
      col_q   <= col_d;
    end
  end

  // Next state, counter advance and next output values.
  always_comb begin
    state_d    = state_q;
    grp_d      = grp_q;
    row_d      = row_q;
    rep_d      = rep_q;
    half_d     = half_q;
    col_d      = col_q;
    bank_sel_d = '0;
    wr_en_d    = 1'b0;
    waddr_d    = '0;
    rd_en_d    = 1'b0;
    raddr_d    = '0;
    shift_d    = '0;
    col_idx_d  = '0;
    half_o_d   = 1'b0;
    busy_d     = (state_q != IDLE);
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.begin_prepare) begin
          state_d = PRELOAD;
          grp_d   = '0;
          row_d   = '0;
        end
      end

      PRELOAD: begin
        if (bus.wr_valid) begin
          wr_en_d    = 1'b1;
          bank_sel_d = GRP_MASK0 << (32'(grp_q) * GRP_BANKS);
          waddr_d    = {NUM_BANK{row_q}};
          if (row_q == ADDR_W'(PRE_ROWS - 1)) begin
            row_d = '0;
            if (grp_q == GW'(GRPS - 1)) begin
              grp_d   = '0;
              state_d = PRIME;
            end else begin
              grp_d = grp_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      PRIME: begin
        rd_en_d = 1'b1;
        raddr_d = {NUM_BANK{row_q}};
        if (bus.pe_ready) begin
          if (row_q == ADDR_W'(PRIME_ROWS - 1)) begin
            row_d   = '0;
            rep_d   = 1'b0;
            half_d  = 1'b0;
            col_d   = '0;
            state_d = SWEEP;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end

      SWEEP: begin
        rd_en_d   = 1'b1;
        raddr_d   = sweep_addr;
        shift_d   = SW'(geom.split);
        col_idx_d = col_q;
        half_o_d  = half_q;
        if (bus.pe_ready) begin
          // Rows in the reuse window go out twice before the row counter moves.
          if (in_win && !rep_q) begin
            rep_d = 1'b1;
          end else begin
            rep_d = 1'b0;
            if (row_q == ADDR_W'(BLK_ROWS - 1)) begin
              row_d = '0;
              if (half_q) begin
                half_d = 1'b0;
                if (col_q == CW'(NUM_COL - 1)) begin
                  col_d   = '0;
                  state_d = DONE;
                end else begin
                  col_d = col_q + 1'b1;
                end
              end else begin
                half_d = 1'b1;
              end
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end

      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_q <= '0;
      wr_en_q    <= 1'b0;
      waddr_q    <= '0;
      rd_en_q    <= 1'b0;
      raddr_q    <= '0;
      shift_q    <= '0;
      col_idx_q  <= '0;
      half_o_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bank_sel_q <= bank_sel_d;
      wr_en_q    <= wr_en_d;
      waddr_q    <= waddr_d;
      rd_en_q    <= rd_en_d;
      raddr_q    <= raddr_d;
      shift_q    <= shift_d;
      col_idx_q  <= col_idx_d;
      half_o_q   <= half_o_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.Bank_sel          = bank_sel_q;
  assign bus.wr_en             = wr_en_q;
  assign bus.write_address_all = waddr_q;
  assign bus.rd_en             = rd_en_q;
  assign bus.rd_address_all    = raddr_q;
  assign bus.shift_value       = shift_q;
  assign bus.col_idx           = col_idx_q;
  assign bus.half              = half_o_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;

endmodule

// File: tb/tb_ref_mem_ctrl_param.sv
// Directed bench for ref_mem_ctrl_param at the default 32-bank geometry.
module tb_ref_mem_ctrl_param;

  localparam int NB = 32;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  ref_mem_ctrl_param_if #(.NUM_BANK(NB), .ADDR_W(AW), .NUM_COL(7)) bus ();

  ref_mem_ctrl_param #(
    .NUM_BANK   (NB),
    .ADDR_W     (AW),
    .GRP_BANKS  (4),
    .PRE_ROWS   (96),
    .BLK_ROWS   (24),
    .NUM_COL    (7),
    .SHIFT_STEP (8),
    .PRIME_ROWS (4),
    .REP_LO     (7),
    .REP_HI     (19)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NB*AW-1:0] rep_addr(input int a);
    logic [NB*AW-1:0] v;
    for (int b = 0; b < NB; b++) v[b*AW +: AW] = AW'(a);
    return v;
  endfunction

  function automatic logic [NB*AW-1:0] sweep_exp(input int c, input int h, input int r);
    logic [NB*AW-1:0] v;
    int split;
    int band;
    split = (c % 4) * 8;
    band  = c / 4 + h;
    for (int b = 0; b < NB; b++) v[b*AW +: AW] = AW'((b < split) ? r + (band + 1) * 24 : r + band * 24);
    return v;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, ".sel"},   bus.Bank_sel, 0);
    check({tag, ".wen"},   bus.wr_en, 0);
    check({tag, ".waddr"}, bus.write_address_all, 0);
    check({tag, ".ren"},   bus.rd_en, 0);
    check({tag, ".raddr"}, bus.rd_address_all, 0);
    check({tag, ".shift"}, bus.shift_value, 0);
    check({tag, ".col"},   bus.col_idx, 0);
    check({tag, ".half"},  bus.half, 0);
    check({tag, ".busy"},  bus.busy, 0);
    check({tag, ".done"},  bus.done, 0);
  endtask

  task automatic start(input logic wv);
    bus.begin_prepare = 1'b1;
    bus.wr_valid      = wv;
    step();
    bus.begin_prepare = 1'b0;
    check("start_busy", bus.busy, 0);
    check("start_wen", bus.wr_en, 0);
  endtask

  task automatic run_preload(input bit toggle, input bit poke);
    for (int i = 0; i < 768; i++) begin
      bus.wr_valid = 1'b1;
      if (poke && i == 100) bus.begin_prepare = 1'b1;
      step();
      bus.begin_prepare = 1'b0;
      check("pre_wen", bus.wr_en, 1);
      check("pre_sel", bus.Bank_sel, 32'hF << (4 * (i / 96)));
      check("pre_addr", bus.write_address_all, rep_addr(i % 96));
      check("pre_busy", bus.busy, 1);
      if (toggle && i < 767) begin
        bus.wr_valid = 1'b0;
        step();
        check("pre_idle_wen", bus.wr_en, 0);
        check("pre_idle_sel", bus.Bank_sel, 0);
      end
    end
  endtask

  task automatic run_prime(input bit stall);
    if (stall) begin
      bus.pe_ready = 1'b0;
      step();
      check("prime_stall_ren", bus.rd_en, 1);
      check("prime_stall_addr", bus.rd_address_all, rep_addr(0));
      bus.pe_ready = 1'b1;
    end
    for (int p = 0; p < 4; p++) begin
      step();
      check("prime_ren", bus.rd_en, 1);
      check("prime_addr", bus.rd_address_all, rep_addr(p));
      check("prime_wen", bus.wr_en, 0);
      check("prime_col", bus.col_idx, 0);
    end
  endtask

  // One loop pass per accepted read; reuse-window rows are issued twice.
  task automatic run_sweep(input bit stall);
    for (int c = 0; c < 7; c++) begin
      for (int h = 0; h < 2; h++) begin
        for (int r = 0; r < 24; r++) begin
          for (int k = 0; k < ((r >= 7 && r <= 19) ? 2 : 1); k++) begin
            if (stall && c == 0 && h == 0 && r == 10 && k == 0) begin
              bus.pe_ready = 1'b0;
              repeat (5) begin
                step();
                check("stall_ren", bus.rd_en, 1);
                check("stall_addr", bus.rd_address_all, sweep_exp(0, 0, 10));
              end
              bus.pe_ready = 1'b1;
            end
            step();
            check("sw_ren", bus.rd_en, 1);
            check("sw_addr", bus.rd_address_all, sweep_exp(c, h, r));
            check("sw_shift", bus.shift_value, (c % 4) * 8);
            check("sw_col", bus.col_idx, c);
            check("sw_half", bus.half, h);
            check("sw_wen", bus.wr_en, 0);
            check("sw_done", bus.done, 0);
            if (c == 1 && h == 0 && r == 0) begin
              check("spot_c1_addr", bus.rd_address_all, {{24{7'd0}}, {8{7'd24}}});
              check("spot_c1_shift", bus.shift_value, 8);
            end
            if (c == 4 && h == 1 && r == 5) begin
              check("spot_c4_addr", bus.rd_address_all, {32{7'd53}});
              check("spot_c4_shift", bus.shift_value, 0);
            end
          end
        end
      end
    end
    step();
    check("end_done", bus.done, 1);
    check("end_ren", bus.rd_en, 0);
    check("end_busy", bus.busy, 1);
    step();
    check("idle_done", bus.done, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n             = 1'b0;
    bus.begin_prepare = 1'b0;
    bus.wr_valid      = 1'b0;
    bus.pe_ready      = 1'b1;
    #1;
    check_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    step();
    check_zero("post_reset");

    // Run 1: wr_valid and pe_ready held high, begin_prepare poked while busy.
    start(1'b1);
    run_preload(1'b0, 1'b1);
    run_prime(1'b0);
    run_sweep(1'b0);

    // Run 2: toggled wr_valid, pe_ready low during preload, PE stalls.
    bus.pe_ready = 1'b0;
    start(1'b0);
    run_preload(1'b1, 1'b0);
    bus.wr_valid = 1'b0;
    run_prime(1'b1);
    run_sweep(1'b1);

    // Run 3: asynchronous reset in column 3 of the sweep.
    start(1'b1);
    run_preload(1'b0, 1'b0);
    run_prime(1'b0);
    repeat (227) step();
    check("pre_rst_col", bus.col_idx, 3);
    check("pre_rst_busy", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    repeat (3) begin
      step();
      check("rst_hold_busy", bus.busy, 0);
      check("rst_hold_done", bus.done, 0);
    end
    #3;
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("rst_rel_busy", bus.busy, 0);
      check("rst_rel_done", bus.done, 0);
      check("rst_rel_ren", bus.rd_en, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
